// File: rtl/banner_ctrl_if.sv
// banner_ctrl_if: control bundle between a sequencer client and banner_ctrl.
//   start      client -> ctrl  one-cycle request to begin a sequence
//   stop       client -> ctrl  one-cycle request to abort to idle
//   mode       client -> ctrl  00 left, 01 right, 10 ping-pong from left, 11 ping-pong from right
//   steps      client -> ctrl  shifts per ping-pong leg
//   pause_len  client -> ctrl  ticks of pause between legs
//   enable     ctrl -> client  high whenever a sequence is active
//   dir        ctrl -> client  1 = shift left, 0 = shift right
//   step       ctrl -> client  one-cycle shift strobe
//   leg_done   ctrl -> client  one-cycle strobe on the last step of a ping-pong leg
//   busy       ctrl -> client  mirror of enable
interface banner_ctrl_if #(
  parameter int unsigned STEP_W = 4
);
  logic              start;
  logic              stop;
  logic [1:0]        mode;
  logic [STEP_W-1:0] steps;
  logic [STEP_W-1:0] pause_len;
  logic              enable;
  logic              dir;
  logic              step;
  logic              leg_done;
  logic              busy;

  modport master (
    output start, stop, mode, steps, pause_len,
    input  enable, dir, step, leg_done, busy
  );

  modport slave (
    input  start, stop, mode, steps, pause_len,
    output enable, dir, step, leg_done, busy
  );
endinterface

// File: rtl/banner_ctrl.sv
// banner_ctrl: sequencer for a scrolling banner. A POWER-bit prescaler produces a tick every
// 2**POWER cycles; in RUN each tick becomes a step strobe. Continuous modes shift forever in one
// direction; ping-pong modes shift 'steps' times per leg, optionally pause for 'pause_len' ticks,
// then reverse direction.
// Ports:
//   clk      single clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      banner_ctrl_if.slave (start/stop/mode/steps/pause_len in; enable/dir/step/
//            leg_done/busy out)
module banner_ctrl #(
  parameter int unsigned POWER  = 23,
  parameter int unsigned STEP_W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  banner_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StPause
  } state_e;

  state_e            state_q, state_d;
  logic [POWER-1:0]  presc_q, presc_d;
  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
  logic [STEP_W-1:0] pause_cnt_q, pause_cnt_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic [STEP_W-1:0] pause_len_q, pause_len_d;
  logic [1:0]        mode_q, mode_d;
  logic              dir_q, dir_d;

  logic              tick;
  logic              ping_pong;
  logic [STEP_W-1:0] steps_last;
  logic              last_step;
  logic              last_pause;
  logic              step_s;
  logic              leg_done_s;

  assign tick       = (presc_q == {POWER{1'b1}});
  assign ping_pong  = mode_q[1];
  // A zero step count behaves as a one-step leg.
  assign steps_last = (steps_q == '0) ? '0 : steps_q - STEP_W'(1);
  assign last_step  = (step_cnt_q == steps_last);
  // Only evaluated in PAUSE, which is entered only with a non-zero pause length.
  assign last_pause = (pause_cnt_q == pause_len_q - STEP_W'(1));

  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    step_cnt_d  = step_cnt_q;
    pause_cnt_d = pause_cnt_q;
    steps_d     = steps_q;
    pause_len_d = pause_len_q;
    mode_d      = mode_q;
    dir_d       = dir_q;
    step_s      = 1'b0;
    leg_done_s  = 1'b0;

    case (state_q)
      StIdle: begin
        presc_d     = '0;
        step_cnt_d  = '0;
        pause_cnt_d = '0;
        // stop wins over a simultaneous start.
        if (bus.start && !bus.stop) begin
          state_d     = StRun;
          mode_d      = bus.mode;
          steps_d     = bus.steps;
          pause_len_d = bus.pause_len;
          dir_d       = ~bus.mode[0];
        end
      end

      StRun: begin
        presc_d = presc_q + POWER'(1);
        if (bus.stop) begin
          // An abort sampled on a tick edge also cancels that tick's strobe.
          state_d     = StIdle;
          presc_d     = '0;
          step_cnt_d  = '0;
          pause_cnt_d = '0;
        end else if (tick) begin
          step_s = 1'b1;
          if (ping_pong) begin
            if (last_step) begin
              leg_done_s = 1'b1;
              step_cnt_d = '0;
              if (pause_len_q != '0) begin
                state_d = StPause;
              end else begin
                dir_d = ~dir_q;
              end
            end else begin
              step_cnt_d = step_cnt_q + STEP_W'(1);
            end
          end
        end
      end

      StPause: begin
        // The prescaler keeps its phase across RUN/PAUSE so tick spacing stays uniform.
        presc_d = presc_q + POWER'(1);
        if (bus.stop) begin
          state_d     = StIdle;
          presc_d     = '0;
          step_cnt_d  = '0;
          pause_cnt_d = '0;
        end else if (tick) begin
          if (last_pause) begin
            pause_cnt_d = '0;
            dir_d       = ~dir_q;
            state_d     = StRun;
          end else begin
            pause_cnt_d = pause_cnt_q + STEP_W'(1);
          end
        end
      end

      default: begin
        state_d     = StIdle;
        presc_d     = '0;
        step_cnt_d  = '0;
        pause_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      presc_q     <= '0;
      step_cnt_q  <= '0;
      pause_cnt_q <= '0;
      steps_q     <= '0;
      pause_len_q <= '0;
      mode_q      <= '0;
      dir_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      step_cnt_q  <= step_cnt_d;
      pause_cnt_q <= pause_cnt_d;
      steps_q     <= steps_d;
      pause_len_q <= pause_len_d;
      mode_q      <= mode_d;
      dir_q       <= dir_d;
    end
  end

  assign bus.enable   = (state_q != StIdle);
  assign bus.busy     = (state_q != StIdle);
  assign bus.dir      = dir_q;
  assign bus.step     = step_s;
  assign bus.leg_done = leg_done_s;

endmodule

// File: tb/tb_banner_ctrl.sv
// Bench for banner_ctrl with POWER=3 (tick every 8 cycles), STEP_W=4. Stimulus pushes the
// expected step strobes (cycle, dir, leg_done) into a queue; a monitor pops one entry on every
// observed step and compares. Cycle numbers are tb edge counts; a run's cycle 0 is the interval
// right after the edge that accepts start.
module tb_banner_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  typedef struct {
    int   cyc;
    logic dir;
    logic ld;
  } exp_t;

  exp_t exp_q[$];

  banner_ctrl_if #(.STEP_W(4)) bus ();

  banner_ctrl #(
    .POWER (3),
    .STEP_W(4)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_step(input int c, input logic d, input logic l);
    exp_t e;
    e.cyc = c;
    e.dir = d;
    e.ld  = l;
    exp_q.push_back(e);
  endtask

  // Monitor: sample away from the active edge.
  always @(negedge clk) begin
    if (reset_n && bus.leg_done && !bus.step) chk("leg_done_without_step", bus.leg_done, 0);
    if (bus.step) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_step", {31'b0, bus.step}, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("step_cycle", cyc, e.cyc);
        chk("step_dir", {31'b0, bus.dir}, {31'b0, e.dir});
        chk("step_leg_done", {31'b0, bus.leg_done}, {31'b0, e.ld});
      end
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input logic [1:0] m, input logic [3:0] s, input logic [3:0] p,
                          input bit hold, output int base);
    bus.mode      = m;
    bus.steps     = s;
    bus.pause_len = p;
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) bus.start = 1'b0;
    base = cyc;
  endtask

  task automatic do_stop(input int c);
    wait_until(c);
    bus.stop = 1'b1;
    @(posedge clk);
    #1;
    bus.stop = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    bus.mode      = 2'b00;
    bus.steps     = 4'd0;
    bus.pause_len = 4'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_enable", {31'b0, bus.enable}, 0);
    chk("rst_busy", {31'b0, bus.busy}, 0);
    chk("rst_dir", {31'b0, bus.dir}, 1);
    chk("rst_step", {31'b0, bus.step}, 0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Continuous left: steps every 8 cycles from cycle 7, never leg_done
    do_start(2'b00, 4'd3, 4'd2, 1'b0, base);
    chk("s1_enable", {31'b0, bus.enable}, 1);
    chk("s1_busy", {31'b0, bus.busy}, 1);
    chk("s1_dir", {31'b0, bus.dir}, 1);
    expect_step(base + 7, 1'b1, 1'b0);
    expect_step(base + 15, 1'b1, 1'b0);
    expect_step(base + 23, 1'b1, 1'b0);
    expect_step(base + 31, 1'b1, 1'b0);
    do_stop(base + 33);
    chk("s1_enable_after_stop", {31'b0, bus.enable}, 0);
    wait_until(base + 45);
    chk("s1_pending", exp_q.size(), 0);

    // Ping-pong from left, 2 steps, 1-tick pause; start held and inputs changed mid-run
    do_start(2'b10, 4'd2, 4'd1, 1'b1, base);
    bus.mode      = 2'b01;
    bus.steps     = 4'd5;
    bus.pause_len = 4'd0;
    chk("s2_dir0", {31'b0, bus.dir}, 1);
    expect_step(base + 7, 1'b1, 1'b0);
    expect_step(base + 15, 1'b1, 1'b1);
    expect_step(base + 31, 1'b0, 1'b0);
    expect_step(base + 39, 1'b0, 1'b1);
    expect_step(base + 55, 1'b1, 1'b0);
    expect_step(base + 63, 1'b1, 1'b1);
    wait_until(base + 20);
    chk("s2_enable_in_pause", {31'b0, bus.enable}, 1);
    wait_until(base + 23);
    chk("s2_dir23", {31'b0, bus.dir}, 1);
    wait_until(base + 24);
    chk("s2_dir24", {31'b0, bus.dir}, 0);
    wait_until(base + 47);
    chk("s2_dir47", {31'b0, bus.dir}, 0);
    wait_until(base + 48);
    chk("s2_dir48", {31'b0, bus.dir}, 1);
    wait_until(base + 60);
    bus.start = 1'b0;
    do_stop(base + 64);
    wait_until(base + 66);
    chk("s2_enable_after_stop", {31'b0, bus.enable}, 0);
    chk("s2_pending", exp_q.size(), 0);

    // Ping-pong from right, steps=0, no pause: every step ends a leg and flips dir
    do_start(2'b11, 4'd0, 4'd0, 1'b0, base);
    chk("s3_dir0", {31'b0, bus.dir}, 0);
    expect_step(base + 7, 1'b0, 1'b1);
    expect_step(base + 15, 1'b1, 1'b1);
    expect_step(base + 23, 1'b0, 1'b1);
    expect_step(base + 31, 1'b1, 1'b1);
    wait_until(base + 8);
    chk("s3_dir8", {31'b0, bus.dir}, 1);
    wait_until(base + 16);
    chk("s3_dir16", {31'b0, bus.dir}, 0);
    do_stop(base + 32);
    wait_until(base + 40);
    chk("s3_pending", exp_q.size(), 0);

    // Start and stop together from idle: stays idle
    bus.mode  = 2'b00;
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    chk("s4_startstop_enable", {31'b0, bus.enable}, 0);
    repeat (10) @(posedge clk);
    #1;
    chk("s4_startstop_enable_later", {31'b0, bus.enable}, 0);

    // Stop on the tick cycle: no step, idle from the next cycle
    do_start(2'b00, 4'd0, 4'd0, 1'b0, base);
    wait_until(base + 7);
    bus.stop = 1'b1;
    #1;
    chk("s4_step_suppressed", {31'b0, bus.step}, 0);
    chk("s4_enable7", {31'b0, bus.enable}, 1);
    @(posedge clk);
    #1;
    bus.stop = 1'b0;
    chk("s4_enable8", {31'b0, bus.enable}, 0);
    wait_until(base + 30);
    chk("s4_pending", exp_q.size(), 0);

    // Asynchronous reset mid-PAUSE (dir is 0 there), then a clean restart
    do_start(2'b11, 4'd1, 4'd3, 1'b0, base);
    expect_step(base + 7, 1'b0, 1'b1);
    wait_until(base + 12);
    chk("s5_dir_in_pause", {31'b0, bus.dir}, 0);
    reset_n = 1'b0;
    #1;
    chk("s5_rst_enable", {31'b0, bus.enable}, 0);
    chk("s5_rst_busy", {31'b0, bus.busy}, 0);
    chk("s5_rst_dir", {31'b0, bus.dir}, 1);
    chk("s5_rst_step", {31'b0, bus.step}, 0);
    chk("s5_rst_leg_done", {31'b0, bus.leg_done}, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    base = cyc;
    wait_until(base + 20);
    chk("s5_idle_after_release", {31'b0, bus.enable}, 0);
    chk("s5_pending", exp_q.size(), 0);

    do_start(2'b00, 4'd0, 4'd0, 1'b0, base);
    chk("s5_restart_enable", {31'b0, bus.enable}, 1);
    chk("s5_restart_dir", {31'b0, bus.dir}, 1);
    expect_step(base + 7, 1'b1, 1'b0);
    expect_step(base + 15, 1'b1, 1'b0);
    do_stop(base + 16);
    wait_until(base + 26);
    chk("s5_restart_pending", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
